// File: rtl/alu_exec_unit.sv
// ---------------------------------------------------------------------------
// alu_exec_unit
//
// Sequential 8-bit ALU execution stage feeding the flag generator. A request
// (A, B, choice) is taken over a valid/ready handshake while the unit is idle.
// Single-cycle opcodes produce their result on the next cycle. MUL runs an
// 8-iteration shift-add. The registered result and the captured request are
// held until the downstream flag stage accepts them.
//
// Optional build macro: ALU_EXEC_DIV_EN
//    When defined, opcode 10001 (DIV) runs an 8-iteration restoring divide
//    through the same iterative state as MUL. When undefined, 10001 behaves
//    like any other unsupported opcode.
//
// Ports:
//    clk, rst          rising-edge clock, synchronous active-high reset
//    in_valid/in_ready request handshake (ready only while idle)
//    A, B, choice      operands and 5-bit opcode
//    out_valid/out_ready result handshake
//    result, result_hi low byte / high byte (MUL product high, DIV remainder)
//    carry_out         carry, borrow or overflow indicator
//    out_A, out_B, out_choice  captured request, valid while out_valid=1
//    busy              unit is not idle
// ---------------------------------------------------------------------------
module alu_exec_unit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [4:0]       choice,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             carry_out,
    output logic [WIDTH-1:0] out_A,
    output logic [WIDTH-1:0] out_B,
    output logic [4:0]       out_choice,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH);

    localparam logic [4:0] OP_ADD = 5'b00000;
    localparam logic [4:0] OP_SUB = 5'b00001;
    localparam logic [4:0] OP_MUL = 5'b00010;
    localparam logic [4:0] OP_AND = 5'b00011;
    localparam logic [4:0] OP_OR  = 5'b00100;
    localparam logic [4:0] OP_XOR = 5'b00101;
    localparam logic [4:0] OP_NOT = 5'b00110;
    localparam logic [4:0] OP_SHL = 5'b00111;
    localparam logic [4:0] OP_SHR = 5'b01000;
    localparam logic [4:0] OP_INC = 5'b01111;
    localparam logic [4:0] OP_DEC = 5'b10000;
`ifdef ALU_EXEC_DIV_EN
    localparam logic [4:0] OP_DIV = 5'b10001;
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_ITER,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [4:0]         choice_q, choice_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [WIDTH-1:0]   resultHi_q, resultHi_d;
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;

    logic [WIDTH-1:0]   aluRes;
    logic               aluCarry;
    logic [2*WIDTH-1:0] accSum;
    logic               lastIter;

    // Handshake and status outputs come straight from the state so they are
    // glitch-free registered values for the flag stage.
    assign in_ready   = (state_q == S_IDLE);
    assign out_valid  = (state_q == S_DONE);
    assign busy       = (state_q != S_IDLE);
    assign result     = result_q;
    assign result_hi  = resultHi_q;
    assign carry_out  = carry_q;
    assign out_A      = a_q;
    assign out_B      = b_q;
    assign out_choice = choice_q;

    // Single-cycle operations are evaluated on the live request inputs so the
    // answer can be registered on the same edge that accepts the request.
    // Unsupported opcodes fall through to all-zero results.
    always_comb begin
        aluRes   = '0;
        aluCarry = 1'b0;
        case (choice)
            OP_ADD: {aluCarry, aluRes} = {1'b0, A} + {1'b0, B};
            OP_SUB: begin
                aluRes   = A - B;
                aluCarry = (A < B);
            end
            OP_AND: aluRes = A & B;
            OP_OR:  aluRes = A | B;
            OP_XOR: aluRes = A ^ B;
            OP_NOT: aluRes = ~A;
            OP_SHL: begin
                aluRes   = {A[WIDTH-2:0], 1'b0};
                aluCarry = A[WIDTH-1];
            end
            OP_SHR: begin
                aluRes   = {1'b0, A[WIDTH-1:1]};
                aluCarry = A[0];
            end
            OP_INC: begin
                aluRes   = A + WIDTH'(1);
                aluCarry = &A;
            end
            OP_DEC: begin
                aluRes   = A - WIDTH'(1);
                aluCarry = ~|A;
            end
            default: begin
                aluRes   = '0;
                aluCarry = 1'b0;
            end
        endcase
    end

`ifdef ALU_EXEC_DIV_EN
    logic [WIDTH:0]   divTrial;
    logic [WIDTH:0]   divDiff;
    logic             divGe;
    logic [WIDTH-1:0] divRem;
    logic [WIDTH-1:0] divQuo;

    // One restoring-divide step. The partial remainder lives in the low half
    // of the accumulator and the dividend shifts out of the top of the
    // multiplier register while quotient bits shift in at the bottom.
    always_comb begin
        divTrial = {acc_q[WIDTH-1:0], mplier_q[WIDTH-1]};
        divDiff  = divTrial - {1'b0, b_q};
        divGe    = (divTrial >= {1'b0, b_q});
        divRem   = divGe ? divDiff[WIDTH-1:0] : divTrial[WIDTH-1:0];
        divQuo   = {mplier_q[WIDTH-2:0], divGe};
    end
`endif

    assign accSum   = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign lastIter = (cnt_q == CNT_W'(WIDTH - 1));

    // Next-state and datapath logic. Every register holds by default; the
    // idle state captures the request, the iterative state advances the
    // shift-add (or divide) by one bit per cycle, and the done state waits
    // for the flag stage to take the result.
    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        choice_d   = choice_q;
        result_d   = result_q;
        resultHi_d = resultHi_q;
        carry_d    = carry_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        mcand_d    = mcand_q;
        mplier_d   = mplier_q;

        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d      = A;
                    b_d      = B;
                    choice_d = choice;
                    cnt_d    = '0;
                    acc_d    = '0;
                    mcand_d  = {{WIDTH{1'b0}}, A};
                    mplier_d = B;
                    if (choice == OP_MUL) begin
                        state_d = S_ITER;
                    end
`ifdef ALU_EXEC_DIV_EN
                    else if (choice == OP_DIV) begin
                        if (B != '0) begin
                            mplier_d = A;
                            state_d  = S_ITER;
                        end else begin
                            result_d   = '1;
                            resultHi_d = A;
                            carry_d    = 1'b1;
                            state_d    = S_DONE;
                        end
                    end
`endif
                    else begin
                        result_d   = aluRes;
                        resultHi_d = '0;
                        carry_d    = aluCarry;
                        state_d    = S_DONE;
                    end
                end
            end
            S_ITER: begin
                cnt_d = cnt_q + CNT_W'(1);
`ifdef ALU_EXEC_DIV_EN
                if (choice_q == OP_DIV) begin
                    acc_d    = {{WIDTH{1'b0}}, divRem};
                    mplier_d = divQuo;
                    if (lastIter) begin
                        result_d   = divQuo;
                        resultHi_d = divRem;
                        carry_d    = 1'b0;
                    end
                end else
`endif
                begin
                    acc_d    = accSum;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    if (lastIter) begin
                        result_d   = accSum[WIDTH-1:0];
                        resultHi_d = accSum[2*WIDTH-1:WIDTH];
                        carry_d    = |accSum[2*WIDTH-1:WIDTH];
                    end
                end
                if (lastIter) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers. Reset abandons any operation in flight
    // and clears everything the flag stage can see.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            a_q        <= '0;
            b_q        <= '0;
            choice_q   <= '0;
            result_q   <= '0;
            resultHi_q <= '0;
            carry_q    <= 1'b0;
            cnt_q      <= '0;
            acc_q      <= '0;
            mcand_q    <= '0;
            mplier_q   <= '0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            choice_q   <= choice_d;
            result_q   <= result_d;
            resultHi_q <= resultHi_d;
            carry_q    <= carry_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            mcand_q    <= mcand_d;
            mplier_q   <= mplier_d;
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// ---------------------------------------------------------------------------
// tb_alu_exec_unit
//
// Directed testbench for alu_exec_unit. Each scenario task drives its own
// vectors and compares the DUT against hand-computed values. Build with
// ALU_EXEC_DIV_EN defined to exercise the divide path.
// ---------------------------------------------------------------------------
module tb_alu_exec_unit;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] A;
    logic [7:0] B;
    logic [4:0] choice;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] result;
    logic [7:0] result_hi;
    logic       carry_out;
    logic [7:0] out_A;
    logic [7:0] out_B;
    logic [4:0] out_choice;
    logic       busy;

    int compared;
    int mismatched;

    alu_exec_unit #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .A          (A),
        .B          (B),
        .choice     (choice),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .result_hi  (result_hi),
        .carry_out  (carry_out),
        .out_A      (out_A),
        .out_B      (out_B),
        .out_choice (out_choice),
        .busy       (busy)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one clock edge and settle 1 ns past it, where both driving
    // and sampling happen.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reset holds everything at zero with the unit idle and ready.
    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        A = 8'h00;
        B = 8'h00;
        choice = 5'd0;
        step();
        step();
        rst = 1'b0;
        compared++;
        if ({in_ready, out_valid, busy} !== 3'b100) begin
            mismatched++;
            $display("[TB] FAIL reset_status got %b want 100", {in_ready, out_valid, busy});
        end
        compared++;
        if ({result, result_hi, carry_out, out_A, out_B, out_choice} !== 38'h0) begin
            mismatched++;
            $display("[TB] FAIL reset_outputs got %h want 0",
                     {result, result_hi, carry_out, out_A, out_B, out_choice});
        end
    endtask

    // ADD with carry: 1-cycle latency and in_ready back two edges later.
    task automatic test_add();
        in_valid = 1'b1;
        A = 8'hF0;
        B = 8'h20;
        choice = 5'b00000;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        compared++;
        if ({out_valid, in_ready, busy} !== 3'b101) begin
            mismatched++;
            $display("[TB] FAIL add_latency got %b want 101", {out_valid, in_ready, busy});
        end
        compared++;
        if ({carry_out, result, result_hi} !== {1'b1, 8'h10, 8'h00}) begin
            mismatched++;
            $display("[TB] FAIL add_result got %h want 11000", {carry_out, result, result_hi});
        end
        compared++;
        if ({out_A, out_B, out_choice} !== {8'hF0, 8'h20, 5'b00000}) begin
            mismatched++;
            $display("[TB] FAIL add_capture got %h want %h",
                     {out_A, out_B, out_choice}, {8'hF0, 8'h20, 5'b00000});
        end
        step();
        compared++;
        if ({out_valid, in_ready} !== 2'b01) begin
            mismatched++;
            $display("[TB] FAIL add_return_idle got %b want 01", {out_valid, in_ready});
        end
    endtask

    // Two MUL vectors: busy for 9 cycles, out_valid on the 9th.
    task automatic test_mul();
        logic [7:0] mA [2];
        logic [7:0] mB [2];
        logic [7:0] expLo [2];
        logic [7:0] expHi [2];
        logic       expC [2];
        int         n;
        int         validAt;
        mA[0] = 8'h10; mB[0] = 8'h20; expLo[0] = 8'h00; expHi[0] = 8'h02; expC[0] = 1'b1;
        mA[1] = 8'h0F; mB[1] = 8'h11; expLo[1] = 8'hFF; expHi[1] = 8'h00; expC[1] = 1'b0;
        for (int v = 0; v < 2; v++) begin
            in_valid = 1'b1;
            A = mA[v];
            B = mB[v];
            choice = 5'b00010;
            out_ready = 1'b1;
            step();
            in_valid = 1'b0;
            n = 0;
            validAt = -1;
            while (busy && n < 20) begin
                if (out_valid && validAt < 0) begin
                    validAt = n;
                    compared++;
                    if ({result_hi, result, carry_out} !== {expHi[v], expLo[v], expC[v]}) begin
                        mismatched++;
                        $display("[TB] FAIL mul_result[%0d] got %h want %h", v,
                                 {result_hi, result, carry_out}, {expHi[v], expLo[v], expC[v]});
                    end
                end
                n++;
                step();
            end
            compared++;
            if (n !== 9 || validAt !== 8) begin
                mismatched++;
                $display("[TB] FAIL mul_timing[%0d] got busy=%0d valid_at=%0d want busy=9 valid_at=8",
                         v, n, validAt);
            end
        end
    endtask

    // SUB held under backpressure while a second request waits at the input.
    task automatic test_backpressure();
        in_valid = 1'b1;
        A = 8'h05;
        B = 8'h07;
        choice = 5'b00001;
        out_ready = 1'b0;
        step();
        A = 8'h01;
        B = 8'h01;
        choice = 5'b00000;
        for (int i = 0; i < 5; i++) begin
            compared++;
            if ({out_valid, in_ready, carry_out, result, out_A, out_choice} !==
                {1'b1, 1'b0, 1'b1, 8'hFE, 8'h05, 5'b00001}) begin
                mismatched++;
                $display("[TB] FAIL hold_cycle[%0d] got %h want %h", i,
                         {out_valid, in_ready, carry_out, result, out_A, out_choice},
                         {1'b1, 1'b0, 1'b1, 8'hFE, 8'h05, 5'b00001});
            end
            step();
        end
        out_ready = 1'b1;
        step();
        compared++;
        if ({in_ready, out_valid} !== 2'b10) begin
            mismatched++;
            $display("[TB] FAIL hold_release got %b want 10", {in_ready, out_valid});
        end
        step();
        in_valid = 1'b0;
        compared++;
        if ({out_valid, result, carry_out, out_A, out_choice} !==
            {1'b1, 8'h02, 1'b0, 8'h01, 5'b00000}) begin
            mismatched++;
            $display("[TB] FAIL queued_add got %h want %h",
                     {out_valid, result, carry_out, out_A, out_choice},
                     {1'b1, 8'h02, 1'b0, 8'h01, 5'b00000});
        end
        step();
    endtask

    // Single-cycle opcode table including wrap and shift-out boundaries.
    task automatic test_single_ops();
        logic [4:0] op  [13];
        logic [7:0] va  [13];
        logic [7:0] vb  [13];
        logic [7:0] er  [13];
        logic       ec  [13];
        op[0]  = 5'b00000; va[0]  = 8'h7F; vb[0]  = 8'h01; er[0]  = 8'h80; ec[0]  = 1'b0;
        op[1]  = 5'b00001; va[1]  = 8'h07; vb[1]  = 8'h05; er[1]  = 8'h02; ec[1]  = 1'b0;
        op[2]  = 5'b00011; va[2]  = 8'hCC; vb[2]  = 8'hAA; er[2]  = 8'h88; ec[2]  = 1'b0;
        op[3]  = 5'b00100; va[3]  = 8'hCC; vb[3]  = 8'hAA; er[3]  = 8'hEE; ec[3]  = 1'b0;
        op[4]  = 5'b00101; va[4]  = 8'hCC; vb[4]  = 8'hAA; er[4]  = 8'h66; ec[4]  = 1'b0;
        op[5]  = 5'b00110; va[5]  = 8'h5A; vb[5]  = 8'h00; er[5]  = 8'hA5; ec[5]  = 1'b0;
        op[6]  = 5'b00111; va[6]  = 8'h81; vb[6]  = 8'h00; er[6]  = 8'h02; ec[6]  = 1'b1;
        op[7]  = 5'b01000; va[7]  = 8'h81; vb[7]  = 8'h00; er[7]  = 8'h40; ec[7]  = 1'b1;
        op[8]  = 5'b01111; va[8]  = 8'hFF; vb[8]  = 8'h00; er[8]  = 8'h00; ec[8]  = 1'b1;
        op[9]  = 5'b01111; va[9]  = 8'h41; vb[9]  = 8'h00; er[9]  = 8'h42; ec[9]  = 1'b0;
        op[10] = 5'b10000; va[10] = 8'h00; vb[10] = 8'h00; er[10] = 8'hFF; ec[10] = 1'b1;
        op[11] = 5'b10000; va[11] = 8'h10; vb[11] = 8'h00; er[11] = 8'h0F; ec[11] = 1'b0;
        op[12] = 5'b01001; va[12] = 8'hFF; vb[12] = 8'hFF; er[12] = 8'h00; ec[12] = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 13; i++) begin
            in_valid = 1'b1;
            A = va[i];
            B = vb[i];
            choice = op[i];
            step();
            in_valid = 1'b0;
            compared++;
            if ({out_valid, result, result_hi, carry_out} !== {1'b1, er[i], 8'h00, ec[i]}) begin
                mismatched++;
                $display("[TB] FAIL op[%0d] choice=%b got %h want %h", i, op[i],
                         {out_valid, result, result_hi, carry_out}, {1'b1, er[i], 8'h00, ec[i]});
            end
            step();
        end
    endtask

    // Reset during the 4th MUL iteration, then a fresh ADD.
    task automatic test_reset_mid_mul();
        in_valid = 1'b1;
        A = 8'h03;
        B = 8'h05;
        choice = 5'b00010;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        compared++;
        if ({out_valid, busy, in_ready} !== 3'b001) begin
            mismatched++;
            $display("[TB] FAIL midmul_status got %b want 001", {out_valid, busy, in_ready});
        end
        compared++;
        if ({result, result_hi, carry_out, out_A, out_B, out_choice} !== 38'h0) begin
            mismatched++;
            $display("[TB] FAIL midmul_outputs got %h want 0",
                     {result, result_hi, carry_out, out_A, out_B, out_choice});
        end
        in_valid = 1'b1;
        A = 8'h01;
        B = 8'h01;
        choice = 5'b00000;
        step();
        in_valid = 1'b0;
        compared++;
        if ({out_valid, result, carry_out} !== {1'b1, 8'h02, 1'b0}) begin
            mismatched++;
            $display("[TB] FAIL midmul_add got %h want 102", {out_valid, result, carry_out});
        end
        step();
    endtask

    // Opcode 10001: divide when enabled, unsupported-opcode zeros otherwise.
    task automatic test_div();
        int n;
        int validAt;
        out_ready = 1'b1;
`ifdef ALU_EXEC_DIV_EN
        in_valid = 1'b1;
        A = 8'h64;
        B = 8'h07;
        choice = 5'b10001;
        step();
        in_valid = 1'b0;
        n = 0;
        validAt = -1;
        while (busy && n < 20) begin
            if (out_valid && validAt < 0) begin
                validAt = n;
                compared++;
                if ({result, result_hi, carry_out} !== {8'h0E, 8'h02, 1'b0}) begin
                    mismatched++;
                    $display("[TB] FAIL div_result got %h want 0e0200",
                             {result, result_hi, carry_out});
                end
            end
            n++;
            step();
        end
        compared++;
        if (n !== 9 || validAt !== 8) begin
            mismatched++;
            $display("[TB] FAIL div_timing got busy=%0d valid_at=%0d want busy=9 valid_at=8",
                     n, validAt);
        end
        in_valid = 1'b1;
        A = 8'h33;
        B = 8'h00;
        step();
        in_valid = 1'b0;
        compared++;
        if ({out_valid, result, result_hi, carry_out} !== {1'b1, 8'hFF, 8'h33, 1'b1}) begin
            mismatched++;
            $display("[TB] FAIL div_by_zero got %h want %h",
                     {out_valid, result, result_hi, carry_out}, {1'b1, 8'hFF, 8'h33, 1'b1});
        end
        step();
`else
        n = 0;
        validAt = 0;
        in_valid = 1'b1;
        A = 8'h64;
        B = 8'h07;
        choice = 5'b10001;
        step();
        in_valid = 1'b0;
        compared++;
        if ({out_valid, result, result_hi, carry_out} !== {1'b1, 8'h00, 8'h00, 1'b0}) begin
            mismatched++;
            $display("[TB] FAIL op10001_zeros got %h want %h",
                     {out_valid, result, result_hi, carry_out}, {1'b1, 8'h00, 8'h00, 1'b0});
        end
        step();
        compared++;
        if ({in_ready, busy, n, validAt} !== {1'b1, 1'b0, 32'd0, 32'd0}) begin
            mismatched++;
            $display("[TB] FAIL op10001_idle got in_ready=%b busy=%b want 1 0", in_ready, busy);
        end
`endif
    endtask

    initial begin
        compared = 0;
        mismatched = 0;
        test_reset();
        test_add();
        test_mul();
        test_backpressure();
        test_single_ops();
        test_reset_mid_mul();
        test_div();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Sequential 8-bit ALU execution stage that sits directly upstream of the flag generator.
- Accepts an opcode/operand pair over a valid/ready handshake and executes it. Single-cycle ops complete immediately; MUL uses an 8-iteration shift-add.
- Presents a registered result, carry_out, and the captured A/B/choice to the flag stage, and holds them until downstream accepts.

Parameters:
- WIDTH, 8, operand/result width; flag stage consumes 8, so only 8 is supported in this design.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operation request present
- in_ready  output  1  unit can accept a request (IDLE only)
- A  input  WIDTH  operand A
- B  input  WIDTH  operand B
- choice  input  5  opcode
- out_valid  output  1  result registers hold a completed operation
- out_ready  input  1  downstream accepts result
- result  output  WIDTH  low result byte
- result_hi  output  WIDTH  MUL high byte; 0 for all other ops
- carry_out  output  1  carry/borrow/overflow indicator, feeds flag stage
- out_A  output  WIDTH  captured A, for flag stage
- out_B  output  WIDTH  captured B, for flag stage
- out_choice  output  5  captured opcode, for flag stage
- busy  output  1  state != IDLE

Behaviour:
- Reset (sync, rst=1 at clk edge):
  - state=IDLE; out_valid=0.
  - result, result_hi, out_A, out_B = 0; carry_out=0; out_choice=0.
  - Iteration counter = 0.
  - Reset mid-MUL or in DONE abandons the op; in_ready=1 the cycle after reset deasserts.
- States:
  - IDLE: in_ready=1. On in_valid, capture A, B, choice. MUL goes to MUL; every other opcode computes and goes to DONE.
  - MUL: 8 cycles. Each cycle: if multiplier LSB=1, add multiplicand to the 16-bit accumulator; shift. After the 8th cycle, go to DONE.
  - DONE: out_valid=1, outputs stable. On out_ready=1, go to IDLE with out_valid=0 next cycle.
- Latency (accept edge to out_valid): 1 cycle for single-cycle ops; 9 cycles for MUL.
  - Minimum issue interval with out_ready held high: 2 cycles for single-cycle ops, 10 for MUL.
- in_ready is 0 in MUL and DONE. A request cannot be accepted in the same cycle as an output transfer.
- in_valid outside IDLE is ignored; the requester holds it.
- Ops (8-bit, unsigned; carry_out as listed):
  - 00000 ADD: {carry_out,result}=A+B
  - 00001 SUB: result=A-B mod 256; carry_out=(A<B) borrow
  - 00010 MUL: {result_hi,result}=A*B; carry_out=|result_hi
  - 00011 AND, 00100 OR, 00101 XOR: bitwise; carry_out=0
  - 00110 NOT: result=~A; carry_out=0
  - 00111 SHL: result=A<<1; carry_out=A[7]
  - 01000 SHR: logical; result=A>>1; carry_out=A[0]
  - 01111 INC: result=A+1 wraps FF->00; carry_out=(A==FF)
  - 10000 DEC: result=A-1 wraps 00->FF; carry_out=(A==00)
  - Any other opcode: result=0, result_hi=0, carry_out=0, 1-cycle latency, still handshaken.
- out_A, out_B, out_choice are registered copies of the captured request, valid whenever out_valid=1.
- result_hi=0 for every non-MUL op.

Optional Feature:
- Macro: ALU_EXEC_DIV_EN.
- Defined: opcode 10001 DIV runs a restoring divide in the MUL state path, 8 cycles, same 9-cycle latency as MUL.
  - result=quotient; result_hi=remainder; carry_out=0.
  - B==0: skip iteration and go to DONE in 1 cycle with result=FF, result_hi=A, carry_out=1.
- Undefined: 10001 is treated as an unsupported opcode (zeros, 1-cycle latency).

Test Plan:
- Reset then ADD A=0xF0 B=0x20, out_ready=1 -> out_valid 1 cycle after accept; result=0x10, carry_out=1, out_choice=00000; in_ready high again 2 cycles after accept.
- MUL A=0x10 B=0x20 -> busy 9 cycles; result=0x00, result_hi=0x02, carry_out=1. Then MUL A=0x0F B=0x11 -> result=0xFF, result_hi=0x00, carry_out=0.
- Backpressure: SUB A=0x05 B=0x07 with out_ready=0 for 5 cycles -> result=0xFE and carry_out=1 held stable, in_ready=0 throughout, second in_valid ignored until transfer.
- Wrap: INC A=0xFF -> result=0x00, carry_out=1; DEC A=0x00 -> result=0xFF, carry_out=1; SHR A=0x81 -> result=0x40, carry_out=1.
- Reset asserted on 4th MUL cycle -> next cycle out_valid=0, busy=0, in_ready=1, all outputs 0; fresh ADD 1+1 -> result=0x02.
- With ALU_EXEC_DIV_EN: DIV 0x64/0x07 -> result=0x0E, result_hi=0x02 after 9 cycles; DIV A=0x33 B=0 -> result=0xFF, result_hi=0x33, carry_out=1 after 1 cycle. Without the macro: 10001 -> all zeros, 1 cycle.
